// File: rtl/tc_pkg.sv
// tc_pkg: shared state type, widths and error-bit positions for the
// thermocouple measurement scheduler.
package tc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_CALC
    } tc_sched_state_t;

    localparam int TC_CODE_W      = 10;
    localparam int TC_TEMP_W      = 16;
    localparam int TC_ERR_TIMEOUT = 0;
    localparam int TC_ERR_OVERRUN = 1;
    localparam int TC_ACC_W       = 18;

    // Four-sample mean, truncated toward zero.
    function automatic logic [TC_TEMP_W-1:0] tc_avg4(
        input logic [TC_ACC_W-1:0] sum
    );
        return sum[TC_ACC_W-1:2];
    endfunction

endpackage

// File: rtl/tc_sched_if.sv
// tc_sched_if: ADC, tc_calc and publish signals of the scheduler.
// slave is the scheduler view, master the surrounding-logic view.
interface tc_sched_if;
    import tc_pkg::*;

    logic                 i_en;
    logic                 o_adc_start;
    logic                 i_adc_valid;
    logic [TC_CODE_W-1:0] i_adc_code;
    logic                 o_calc_start;
    logic [TC_CODE_W-1:0] o_calc_code;
    logic [TC_TEMP_W-1:0] i_calc_temp;
    logic                 i_calc_done;
    logic [TC_TEMP_W-1:0] o_temp;
    logic                 o_valid;
    logic [1:0]           o_err;
    logic                 i_err_clr;

    modport slave (
        input  i_en,
        input  i_adc_valid,
        input  i_adc_code,
        input  i_calc_temp,
        input  i_calc_done,
        input  i_err_clr,
        output o_adc_start,
        output o_calc_start,
        output o_calc_code,
        output o_temp,
        output o_valid,
        output o_err
    );

    modport master (
        output i_en,
        output i_adc_valid,
        output i_adc_code,
        output i_calc_temp,
        output i_calc_done,
        output i_err_clr,
        input  o_adc_start,
        input  o_calc_start,
        input  o_calc_code,
        input  o_temp,
        input  o_valid,
        input  o_err
    );

endinterface

// File: rtl/tc_tick_timer.sv
// tc_tick_timer: free-running 0..PERIOD-1 counter while enabled, held at 0
// otherwise; tick_o marks the last count of each period.
module tc_tick_timer #(
    parameter int PERIOD = 1000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [15:0] LAST = 16'(PERIOD - 1);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/tc_sched.sv
// tc_sched: periodic ADC request -> tc_calc -> registered temperature.
// Define TC_SCHED_AVG_EN to publish the mean of every four captures.
module tc_sched
    import tc_pkg::*;
#(
    parameter int PERIOD  = 1000,
    parameter int TIMEOUT = 64
) (
    input  logic      i_clk,
    input  logic      i_rst,
    tc_sched_if.slave bus
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    tc_sched_state_t      state_q, state_d;
    logic [7:0]           wait_q, wait_d;
    logic                 adc_start_q, adc_start_d;
    logic                 calc_start_q, calc_start_d;
    logic [TC_CODE_W-1:0] code_q, code_d;
    logic [TC_TEMP_W-1:0] temp_q, temp_d;
    logic                 valid_q, valid_d;
    logic [1:0]           err_q, err_d, err_set;
    logic                 tick, wait_last, capture, timeout;

    tc_tick_timer #(
        .PERIOD (PERIOD)
    ) u_timer (
        .clk_i  (i_clk),
        .rst_i  (i_rst),
        .en_i   (bus.i_en),
        .tick_o (tick)
    );

    assign wait_last = (wait_q == WAIT_LAST);

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q + 8'd1;
        adc_start_d  = 1'b0;
        calc_start_d = 1'b0;
        code_d       = code_q;
        capture      = 1'b0;
        timeout      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                wait_d = '0;
                if (tick) begin
                    state_d     = ST_CONV;
                    adc_start_d = 1'b1;
                end
            end
            ST_CONV: begin
                if (bus.i_adc_valid) begin
                    code_d       = bus.i_adc_code;
                    calc_start_d = 1'b1;
                    state_d      = ST_CALC;
                end else if (wait_last) begin
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (bus.i_calc_done) begin
                    capture = 1'b1;
                    state_d = ST_IDLE;
                end else if (wait_last) begin
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // wait counter restarts on every state entry
        if (state_d != state_q) begin
            wait_d = '0;
        end
    end

    always_comb begin
        err_set                 = 2'b00;
        err_set[TC_ERR_TIMEOUT] = timeout;
        err_set[TC_ERR_OVERRUN] = tick && (state_q != ST_IDLE);
        err_d = (bus.i_err_clr ? 2'b00 : err_q) | err_set;
    end

`ifdef TC_SCHED_AVG_EN
    logic [TC_ACC_W-1:0] acc_q, acc_d, sum;
    logic [1:0]          cnt_q, cnt_d;

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        temp_d  = temp_q;
        valid_d = 1'b0;
        sum     = acc_q + TC_ACC_W'(bus.i_calc_temp);
        if (timeout) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (capture) begin
            if (cnt_q == 2'd3) begin
                temp_d  = tc_avg4(sum);
                valid_d = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        temp_d  = temp_q;
        valid_d = 1'b0;
        if (capture) begin
            temp_d  = bus.i_calc_temp;
            valid_d = 1'b1;
        end
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            wait_q       <= '0;
            adc_start_q  <= 1'b0;
            calc_start_q <= 1'b0;
            code_q       <= '0;
            temp_q       <= '0;
            valid_q      <= 1'b0;
            err_q        <= 2'b00;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            adc_start_q  <= adc_start_d;
            calc_start_q <= calc_start_d;
            code_q       <= code_d;
            temp_q       <= temp_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
        end
    end

    assign bus.o_adc_start  = adc_start_q;
    assign bus.o_calc_start = calc_start_q;
    assign bus.o_calc_code  = code_q;
    assign bus.o_temp       = temp_q;
    assign bus.o_valid      = valid_q;
    assign bus.o_err        = err_q;

endmodule
